// File: rtl/subtractor_32.sv
// 32-bit registered subtractor: dif = input1 - input2 via an explicit ripple chain of
// full-adder slices computing input1 + ~input2 + 1; carry_out = 1 means no borrow.

module full_adder_1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic half_s;

    assign half_s = a ^ b;
    assign s      = half_s ^ cin;
    assign cout   = (a & b) | (cin & half_s);
endmodule

module subtractor_32 (
    output logic [31:0] dif,
    output logic        carry_out,
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    input  logic        clk,
    input  logic        rst
);
    logic [31:0] b_inv_s;
    logic [31:0] raw_dif_s;
    logic [32:0] carry_s;
    logic [31:0] dif_r;
    logic        carry_out_r;

    assign b_inv_s    = ~input2;
    // Seeding the chain with 1 supplies the +1 of the two's complement.
    assign carry_s[0] = 1'b1;

    for (genvar i = 0; i < 32; i++) begin : g_slice
        full_adder_1 u_fa (
            .a    (input1[i]),
            .b    (b_inv_s[i]),
            .cin  (carry_s[i]),
            .s    (raw_dif_s[i]),
            .cout (carry_s[i+1])
        );
    end

    // Output register: reset clears both outputs, otherwise capture the chain result.
    always_ff @(posedge clk) begin
        if (rst) begin
            dif_r       <= 32'h0000_0000;
            carry_out_r <= 1'b0;
        end else begin
            dif_r       <= raw_dif_s;
            carry_out_r <= carry_s[32];
        end
    end

    assign dif       = dif_r;
    assign carry_out = carry_out_r;
endmodule

// File: tb/tb_subtractor_32.sv
// Scoreboard bench for subtractor_32: expected {carry_out, dif} pushed when driven,
// popped and compared one cycle later on the falling edge.

module tb_subtractor_32;
    logic        clk;
    logic        rst;
    logic [31:0] input1;
    logic [31:0] input2;
    logic [31:0] dif;
    logic        carry_out;

    logic [32:0] exp_q[$];
    logic [32:0] exp_v;
    logic [32:0] got_v;
    int          checks;
    int          errors;

    subtractor_32 dut (
        .dif       (dif),
        .carry_out (carry_out),
        .input1    (input1),
        .input2    (input2),
        .clk       (clk),
        .rst       (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic r);
        logic [31:0] d;
        if (r) return 33'h0;
        d = a - b;
        return {(a >= b), d};
    endfunction

    task automatic test_reset();
        logic [31:0] a_v;
        logic [31:0] b_v;
        a_v = 32'h1234_5678;
        b_v = 32'h0000_0001;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst    = (i == 0);
            input1 = a_v;
            input2 = b_v;
            exp_q.push_back(model(a_v, b_v, rst));
            @(negedge clk);
            got_v = {carry_out, dif};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL reset_%0d scoreboard empty", i);
            end else begin
                exp_v = exp_q.pop_front();
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL reset_%0d got=%h exp=%h", i, got_v, exp_v);
                end
            end
        end
        // Explicit spec values for the deassert case.
        checks++;
        if (got_v !== {1'b1, 32'h1234_5677}) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", got_v, {1'b1, 32'h1234_5677});
        end
    endtask

    task automatic test_vectors();
        logic [31:0] a_tab[6];
        logic [31:0] b_tab[6];
        a_tab = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0005, 32'h8000_0000};
        b_tab = '{32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst    = 1'b0;
            input1 = a_tab[i];
            input2 = b_tab[i];
            exp_q.push_back(model(a_tab[i], b_tab[i], 1'b0));
            @(negedge clk);
            got_v = {carry_out, dif};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL vector_%0d scoreboard empty", i);
            end else begin
                exp_v = exp_q.pop_front();
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL vector_%0d got=%h exp=%h", i, got_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic r_tab[3];
        r_tab = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst    = r_tab[i];
            input1 = 32'hDEAD_BEEF;
            input2 = 32'h0000_1000 + 32'(i);
            exp_q.push_back(model(input1, input2, rst));
            @(negedge clk);
            got_v = {carry_out, dif};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL midreset_%0d scoreboard empty", i);
            end else begin
                exp_v = exp_q.pop_front();
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL midreset_%0d got=%h exp=%h", i, got_v, exp_v);
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_v;
        logic [31:0] b_v;
        for (int i = 0; i <= 1000; i++) begin
            @(negedge clk);
            if (i > 0) begin
                got_v = {carry_out, dif};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_%0d scoreboard empty", i);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (got_v !== exp_v) begin
                        errors++;
                        $display("FAIL b2b_%0d got=%h exp=%h", i, got_v, exp_v);
                    end
                end
            end
            if (i < 1000) begin
                a_v = $urandom;
                b_v = $urandom;
                // Sprinkle equal and near-equal operands to exercise the borrow boundary.
                if (i % 50 == 0) b_v = a_v;
                if (i % 50 == 1) b_v = a_v + 32'h1;
                rst    = 1'b0;
                input1 = a_v;
                input2 = b_v;
                exp_q.push_back(model(a_v, b_v, 1'b0));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        input1 = 32'h0;
        input2 = 32'h0;
        test_reset();
        test_vectors();
        test_reset_midstream();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
